traffic_sensor_conditioner: RTL and testbench

//   Sits directly upstream of the traffic-light FSM. Turns the two raw roadside

---
 rtl/traffic_sensor_conditioner_if.sv | 24 ++
 rtl/traffic_sensor_conditioner.sv | 108 ++++++++++
 tb/tb_traffic_sensor_conditioner.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_conditioner_if.sv
// Detector / traffic-present bus between the roadside sensor front end and the
// traffic-light FSM. The master drives raw detectors and the counter clear; the
// slave (the conditioner) returns the cleaned bus and monitoring counts.
interface traffic_sensor_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             sens_a;
    logic             sens_b;
    logic             clr_cnt;
    logic [1:0]       T;
    logic [1:0]       arrive;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output sens_a, sens_b, clr_cnt,
        input  T, arrive, cnt_a, cnt_b
    );

    modport slave (
        input  sens_a, sens_b, clr_cnt,
        output T, arrive, cnt_a, cnt_b
    );
endinterface

// File: rtl/traffic_sensor_conditioner.sv
// Conditions two raw vehicle detectors into the registered traffic-present bus T.
// Each street: 2-flop synchroniser -> debounce -> occupancy hold FSM, plus a
// saturating arrival counter. Channel 0 = street A, channel 1 = street B.
module traffic_sensor_conditioner #(
    parameter int DEB_CYC  = 4,
    parameter int HOLD_CYC = 16,
    parameter int CNT_W    = 8
) (
    input logic                         clk,
    input logic                         rst,
    traffic_sensor_conditioner_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC) + 1;
    localparam int DW = $clog2(DEB_CYC) + 1;

    typedef enum logic [1:0] {IDLE, OCC, HOLD} state_t;

    logic [1:0] raw;
    assign raw = {bus.sens_b, bus.sens_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic             s1_q, s2_q;
        logic             deb_q, deb_d;
        logic [DW-1:0]    dcnt_q, dcnt_d;
        logic             arrive_q, arrive_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        state_t           state_q, state_d;
        logic [HW-1:0]    hold_q, hold_d;

        // Debounce the synchronised level, flag the accepted 0->1 and count it.
        always_comb begin
            deb_d    = deb_q;
            dcnt_d   = '0;
            if (s2_q != deb_q) begin
                if (dcnt_q == DW'(DEB_CYC - 1)) begin
                    deb_d = s2_q;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            arrive_d = ~deb_q & deb_d;
            cnt_d    = cnt_q;
            // A clear beats an increment on the same edge; the pulse still goes out.
            if (bus.clr_cnt) begin
                cnt_d = '0;
            end else if (arrive_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Occupancy FSM: hold T high for HOLD_CYC cycles after the car leaves.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            case (state_q)
                IDLE: begin
                    if (deb_q) state_d = OCC;
                end
                OCC: begin
                    if (!deb_q) begin
                        state_d = HOLD;
                        hold_d  = '0;
                    end
                end
                HOLD: begin
                    if (deb_q) begin
                        state_d = OCC;
                    end else if (hold_q == HW'(HOLD_CYC - 1)) begin
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Channel state registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                deb_q    <= 1'b0;
                dcnt_q   <= '0;
                arrive_q <= 1'b0;
                cnt_q    <= '0;
                state_q  <= IDLE;
                hold_q   <= '0;
            end else begin
                s1_q     <= raw[gi];
                s2_q     <= s1_q;
                deb_q    <= deb_d;
                dcnt_q   <= dcnt_d;
                arrive_q <= arrive_d;
                cnt_q    <= cnt_d;
                state_q  <= state_d;
                hold_q   <= hold_d;
            end
        end

        // T is a pure decode of the state register, so it never glitches on inputs.
        assign bus.T[gi]      = (state_q != IDLE);
        assign bus.arrive[gi] = arrive_q;
    end

    assign bus.cnt_a = g_ch[0].cnt_q;
    assign bus.cnt_b = g_ch[1].cnt_q;
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner. Two instances share stimulus:
// one with 8-bit counters, one with 3-bit counters for saturation. A window-based
// behavioural model is compared every cycle; literal checks pin key timings.
`timescale 1ns/1ps
module tb_traffic_sensor_conditioner;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst, sens_a, sens_b, clr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_sensor_conditioner_if #(.CNT_W(8)) bus8 ();
    traffic_sensor_conditioner_if #(.CNT_W(3)) bus3 ();

    assign bus8.sens_a  = sens_a;
    assign bus8.sens_b  = sens_b;
    assign bus8.clr_cnt = clr_cnt;
    assign bus3.sens_a  = sens_a;
    assign bus3.sens_b  = sens_b;
    assign bus3.clr_cnt = clr_cnt;

    traffic_sensor_conditioner #(.DEB_CYC(DEB), .HOLD_CYC(HOLD), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    traffic_sensor_conditioner #(.DEB_CYC(DEB), .HOLD_CYC(HOLD), .CNT_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sync: raw seen two edges late. Debounce: accept a level once the last DEB
    // synchronised samples all agree and differ from the current level.
    // T: high while the debounced level was high at any of the last HOLD+1 samples.
    bit pipe_m [2][2];
    bit win_m  [2][DEB];
    int wn_m   [2];
    bit deb_m  [2];
    int age_m  [2];
    bit t_m    [2];
    bit arr_m  [2];
    int c8_m   [2];
    int c3_m   [2];
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                pipe_m[c][0] = 1'b0;
                pipe_m[c][1] = 1'b0;
                wn_m[c]      = 0;
                deb_m[c]     = 1'b0;
                age_m[c]     = 1000;
                t_m[c]       = 1'b0;
                arr_m[c]     = 1'b0;
                c8_m[c]      = 0;
                c3_m[c]      = 0;
            end else begin
                bit obs, old, same;
                obs          = pipe_m[c][0];
                pipe_m[c][0] = pipe_m[c][1];
                pipe_m[c][1] = (c == 0) ? sens_a : sens_b;
                for (int i = 0; i < DEB - 1; i++) win_m[c][i] = win_m[c][i+1];
                win_m[c][DEB-1] = obs;
                if (wn_m[c] < DEB) wn_m[c]++;
                same = (wn_m[c] == DEB);
                for (int i = 0; i < DEB; i++) if (win_m[c][i] != obs) same = 1'b0;
                old = deb_m[c];
                if (same && (obs != old)) deb_m[c] = obs;
                if (old) age_m[c] = 0;
                else if (age_m[c] < 1000) age_m[c]++;
                t_m[c]   = (age_m[c] <= HOLD);
                arr_m[c] = !old && deb_m[c];
                if (clr_cnt) begin
                    c8_m[c] = 0;
                    c3_m[c] = 0;
                end else if (arr_m[c]) begin
                    if (c8_m[c] < 255) c8_m[c]++;
                    if (c3_m[c] < 7)   c3_m[c]++;
                end
            end
        end
        if (rst) model_ok = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("T8",      32'(bus8.T),      32'({t_m[1], t_m[0]}));
            chk("T3",      32'(bus3.T),      32'({t_m[1], t_m[0]}));
            chk("arrive8", 32'(bus8.arrive), 32'({arr_m[1], arr_m[0]}));
            chk("arrive3", 32'(bus3.arrive), 32'({arr_m[1], arr_m[0]}));
            chk("cnt_a8",  32'(bus8.cnt_a),  32'(c8_m[0]));
            chk("cnt_b8",  32'(bus8.cnt_b),  32'(c8_m[1]));
            chk("cnt_a3",  32'(bus3.cnt_a),  32'(c3_m[0]));
            chk("cnt_b3",  32'(bus3.cnt_b),  32'(c3_m[1]));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; sens_a = 1'b1; sens_b = 1'b1; clr_cnt = 1'b0;

        // Reset held with detectors active: everything stays zero.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_T",      32'(bus8.T),      32'h0);
            chk("rst_arrive", 32'(bus8.arrive), 32'h0);
            chk("rst_cnt_a",  32'(bus8.cnt_a),  32'h0);
            chk("rst_cnt_b",  32'(bus8.cnt_b),  32'h0);
        end
        @(negedge clk); rst = 1'b0; sens_a = 1'b0; sens_b = 1'b0;
        repeat (5) @(negedge clk);

        // Three-cycle glitch on A is rejected.
        sens_a = 1'b1;
        repeat (3) @(negedge clk);
        sens_a = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            chk("glitch_T0",  32'(bus8.T[0]),   32'h0);
            chk("glitch_arr", 32'(bus8.arrive), 32'h0);
        end
        chk("glitch_cnt_a", 32'(bus8.cnt_a), 32'h0);

        // Clean car on A: arrive after edge 6, T after edge 7, fall after edge 23.
        @(negedge clk); sens_a = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("car_arr_e5", 32'(bus8.arrive), 32'h0);
        @(posedge clk); #1;
        chk("car_arr_e6", 32'(bus8.arrive), 32'h1);
        chk("car_cnt_e6", 32'(bus8.cnt_a),  32'h1);
        chk("car_T0_e6",  32'(bus8.T[0]),   32'h0);
        @(posedge clk); #1;
        chk("car_T0_e7",  32'(bus8.T[0]),   32'h1);
        chk("car_arr_e7", 32'(bus8.arrive), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); sens_a = 1'b0;
        repeat (22) @(posedge clk); #1;
        chk("hold_T0_e22", 32'(bus8.T[0]), 32'h1);
        @(posedge clk); #1;
        chk("hold_T0_e23", 32'(bus8.T[0]), 32'h0);

        // B car leaves for 12 cycles and returns while in hold: T[1] stays up.
        @(negedge clk); sens_b = 1'b1;
        repeat (10) @(negedge clk);
        sens_b = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("redet_T1", 32'(bus8.T[1]), 32'h1);
        end
        sens_b = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("redet_T1b", 32'(bus8.T[1]), 32'h1);
        end
        sens_b = 1'b0;
        repeat (30) @(negedge clk);
        chk("redet_cnt_b", 32'(bus8.cnt_b), 32'h2);
        chk("redet_T1_end", 32'(bus8.T[1]), 32'h0);

        // Clear, then nine clean arrivals on A: 3-bit count saturates at 7.
        clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        chk("clr_cnt_b", 32'(bus8.cnt_b), 32'h0);
        for (int k = 0; k < 9; k++) begin
            sens_a = 1'b1;
            repeat (6) @(negedge clk);
            sens_a = 1'b0;
            repeat (6) @(negedge clk);
        end
        chk("sat_cnt_a3", 32'(bus3.cnt_a), 32'h7);
        chk("sat_cnt_a8", 32'(bus8.cnt_a), 32'h9);

        // Clear coincident with the next arrival: count 0, pulse still emitted.
        sens_a = 1'b1;
        repeat (5) @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        chk("clrarr_arr3", 32'(bus3.arrive[0]), 32'h1);
        chk("clrarr_cnt3", 32'(bus3.cnt_a),     32'h0);
        chk("clrarr_cnt8", 32'(bus8.cnt_a),     32'h0);
        @(negedge clk); clr_cnt = 1'b0;
        repeat (4) @(negedge clk);
        sens_a = 1'b0;
        repeat (30) @(negedge clk);

        // Both streets occupied, then reset while A is in hold.
        sens_a = 1'b1; sens_b = 1'b1;
        repeat (8) @(posedge clk); #1;
        chk("both_T", 32'(bus8.T), 32'h3);
        @(negedge clk); sens_a = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("both_T_hold", 32'(bus8.T), 32'h3);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_T",      32'(bus8.T),      32'h0);
        chk("midrst_arrive", 32'(bus8.arrive), 32'h0);
        chk("midrst_cnt_a",  32'(bus8.cnt_a),  32'h0);
        chk("midrst_cnt_b",  32'(bus8.cnt_b),  32'h0);
        @(negedge clk); rst = 1'b0; sens_b = 1'b0; sens_a = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("post_T0_e6", 32'(bus8.T[0]), 32'h0);
        @(posedge clk); #1;
        chk("post_T0_e7", 32'(bus8.T[0]), 32'h1);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
